ysyx_24100027_ifu: RTL and testbench

Multi-cycle instruction fetch unit for the NPC core. It holds the architectural PC, fetches one instruction per step from instruction memory over a valid/ready request/response pair, and presents it to decode. On each commit it computes the next PC from the branch-control outputs `PCActr` and `PCBctr`. A commit counter and a sticky misalignment fault are included.

---
 rtl/ysyx_24100027_ifu_if.sv | 28 ++
 rtl/ysyx_24100027_ifu.sv | 56 +++++
 tb/tb_ysyx_24100027_ifu.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ysyx_24100027_ifu_if.sv
// ysyx_24100027_ifu_if: fetch, decode and commit signals between the IFU and its neighbours
interface ysyx_24100027_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        commit_valid;
  logic        PCActr;
  logic        PCBctr;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        misalign;
  logic [31:0] inst_count;
  modport master (
    output imem_req_valid, imem_addr, imem_rsp_ready, inst_valid, inst, inst_pc, misalign, inst_count,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, commit_valid, PCActr, PCBctr, imm, rs1
  );
  modport slave (
    input  imem_req_valid, imem_addr, imem_rsp_ready, inst_valid, inst, inst_pc, misalign, inst_count,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, commit_valid, PCActr, PCBctr, imm, rs1
  );
endinterface

// File: rtl/ysyx_24100027_ifu.sv
// ysyx_24100027_ifu: multi-cycle fetch unit holding the PC, with commit counter and sticky misalignment fault
module ysyx_24100027_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  ysyx_24100027_ifu_if.master bus
);
  typedef enum logic [2:0] {BOOT, REQ, WAIT, ISSUE, EXEC, ERR} state_e;
  state_e      state_q;
  logic [31:0] pc_q, inst_q, cnt_q, pc_d, sum;
  logic        mis_q;
  // jalr-style targets (register base) drop bit 0 before the alignment check
  always_comb begin
    sum  = (bus.PCBctr ? bus.rs1 : pc_q) + (bus.PCActr ? bus.imm : 32'd4);
    pc_d = {sum[31:1], sum[0] & ~bus.PCBctr};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      case (state_q)
        BOOT:    state_q <= REQ;
        REQ:     if (bus.imem_req_ready) state_q <= WAIT;
        WAIT:    if (bus.imem_rsp_valid) begin
          inst_q  <= bus.imem_rsp_data;
          state_q <= ISSUE;
        end
        ISSUE:   if (bus.inst_ready) state_q <= EXEC;
        EXEC:    if (bus.commit_valid) begin
          pc_q <= pc_d;
          if (pc_d[1:0] == 2'b00) begin
            cnt_q   <= cnt_q + 32'd1;
            state_q <= REQ;
          end else begin
            mis_q   <= 1'b1;
            state_q <= ERR;
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end
  assign bus.imem_req_valid = state_q == REQ;
  assign bus.imem_rsp_ready = state_q == WAIT;
  assign bus.inst_valid     = state_q == ISSUE;
  assign bus.imem_addr      = pc_q;
  assign bus.inst_pc        = pc_q;
  assign bus.inst           = inst_q;
  assign bus.misalign       = mis_q;
  assign bus.inst_count     = cnt_q;
endmodule

// File: tb/tb_ysyx_24100027_ifu.sv
// tb_ysyx_24100027_ifu: directed fetch/commit scenarios checked against a handshake-level model every cycle
module tb_ysyx_24100027_ifu;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0, n_bad = 0, req_cnt = 0;
  ysyx_24100027_ifu_if bus ();
  ysyx_24100027_ifu dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction
  assign bus.imem_rsp_data = mem_word(bus.imem_addr);
  function automatic logic [31:0] next_pc(logic [31:0] pc, logic [31:0] r1, logic [31:0] im, logic a, logic b);
    logic [32:0] s;
    logic [31:0] t;
    s = {1'b0, b ? r1 : pc} + {1'b0, a ? im : 32'd4};
    t = s[31:0];
    if (b && t % 2 == 1) t = t - 1;
    return t;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  localparam int P_BOOT = 0, P_REQ = 1, P_WAIT = 2, P_ISS = 3, P_EXEC = 4, P_ERR = 5;
  int          ph;
  logic [31:0] m_pc, m_inst, m_cnt, t;
  logic        m_mis;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = P_BOOT; m_pc = 32'h8000_0000; m_inst = 0; m_cnt = 0; m_mis = 0;
    end else begin
      case (ph)
        P_BOOT: ph = P_REQ;
        P_REQ:  if (bus.imem_req_ready) ph = P_WAIT;
        P_WAIT: if (bus.imem_rsp_valid) begin m_inst = mem_word(m_pc); ph = P_ISS; end
        P_ISS:  if (bus.inst_ready) ph = P_EXEC;
        P_EXEC: if (bus.commit_valid) begin
          t = next_pc(m_pc, bus.rs1, bus.imm, bus.PCActr, bus.PCBctr);
          m_pc = t;
          if (t % 4 == 0) begin m_cnt = m_cnt + 1; ph = P_REQ; end
          else begin m_mis = 1; ph = P_ERR; end
        end
        default: ;
      endcase
    end
  end
  always @(posedge clk) if (rst_n && bus.imem_req_valid && bus.imem_req_ready) req_cnt++;
  always @(negedge clk) begin
    chk("req_valid", 32'(bus.imem_req_valid), 32'(ph == P_REQ));
    chk("rsp_ready", 32'(bus.imem_rsp_ready), 32'(ph == P_WAIT));
    chk("inst_valid", 32'(bus.inst_valid), 32'(ph == P_ISS));
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("inst_pc", bus.inst_pc, m_pc);
    chk("inst", bus.inst, m_inst);
    chk("misalign", 32'(bus.misalign), 32'(m_mis));
    chk("inst_count", bus.inst_count, m_cnt);
  end
  task automatic drive(logic rq, logic rv, logic ir, logic cv, logic a, logic b, logic [31:0] im, logic [31:0] r1);
    bus.imem_req_ready = rq; bus.imem_rsp_valid = rv; bus.inst_ready = ir; bus.commit_valid = cv;
    bus.PCActr = a; bus.PCBctr = b; bus.imm = im; bus.rs1 = r1;
    @(posedge clk); #1;
  endtask
  task automatic instr(logic a, logic b, logic [31:0] im, logic [31:0] r1);
    repeat (4) drive(1, 1, 1, 1, a, b, im, r1);
  endtask
  task automatic pin(string nm, logic [31:0] addr, logic [31:0] cnt);
    chk({nm, "_addr"}, bus.imem_addr, addr);
    chk({nm, "_count"}, bus.inst_count, cnt);
    chk({nm, "_reqv"}, 32'(bus.imem_req_valid), 32'd1);
  endtask
  initial begin
    rst_n = 1'b1;
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.inst_ready = 0; bus.commit_valid = 0;
    bus.PCActr = 0; bus.PCBctr = 0; bus.imm = 0; bus.rs1 = 0;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_reqv", 32'(bus.imem_req_valid), 0);
    chk("rst_rspr", 32'(bus.imem_rsp_ready), 0);
    chk("rst_instv", 32'(bus.inst_valid), 0);
    chk("rst_addr", bus.imem_addr, 32'h8000_0000);
    chk("rst_inst", bus.inst, 0);
    chk("rst_mis", 32'(bus.misalign), 0);
    chk("rst_cnt", bus.inst_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    pin("boot", 32'h8000_0000, 0);
    chk("boot_instv", 32'(bus.inst_valid), 0);
    instr(0, 0, 0, 0);                       pin("seq", 32'h8000_0004, 1);
    instr(0, 1, 0, 32'hFFFF_FFF8);           pin("top", 32'hFFFF_FFFC, 2);
    instr(0, 0, 0, 0);                       pin("wrap", 32'h0000_0000, 3);
    instr(0, 1, 0, 32'h8000_000C);           pin("rs1p4", 32'h8000_0010, 4);
    instr(1, 0, 32'hFFFF_FFF0, 0);           pin("branch", 32'h8000_0000, 5);
    instr(1, 1, 32'd4, 32'h8000_1001);       pin("jalr", 32'h8000_1004, 6);
    chk("jalr_mis", 32'(bus.misalign), 0);
    req_cnt = 0;
    repeat (3) begin
      drive(0, 1, 1, 1, 0, 0, 0, 0);
      chk("bp_reqv", 32'(bus.imem_req_valid), 1);
      chk("bp_addr", bus.imem_addr, 32'h8000_1004);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    chk("bp_one_req", 32'(req_cnt), 1);
    repeat (3) begin
      drive(0, 0, 0, 1, 1, 0, 32'd2, 0);
      chk("stall_inst", bus.inst, 32'h8000_1004 ^ 32'h1357_9BDF);
      chk("stall_pc", bus.inst_pc, 32'h8000_1004);
      chk("stall_instv", 32'(bus.inst_valid), 1);
    end
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    pin("after_bp", 32'h8000_1008, 7);
    rst_n = 1'b0; #1;
    chk("mid_rst_addr", bus.imem_addr, 32'h8000_0000);
    chk("mid_rst_cnt", bus.inst_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pin("reboot", 32'h8000_0000, 0);
    instr(1, 0, 32'd2, 0);
    chk("mis_flag", 32'(bus.misalign), 1);
    chk("mis_pc", bus.imem_addr, 32'h8000_0002);
    chk("mis_cnt", bus.inst_count, 0);
    req_cnt = 0;
    repeat (20) drive(1, 1, 1, 1, 0, 0, 0, 0);
    chk("err_no_req", 32'(req_cnt), 0);
    chk("err_reqv", 32'(bus.imem_req_valid), 0);
    rst_n = 1'b0; #1;
    chk("err_rst_mis", 32'(bus.misalign), 0);
    chk("err_rst_addr", bus.imem_addr, 32'h8000_0000);
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
